// File: rtl/decoder_pkg.sv
// Shared types and constants for the 1035-pattern decoder path.
// Word width, match value and serial assembler state encoding.
package decoder_pkg;

  localparam int          WORD_W      = 16;
  localparam logic [15:0] MATCH_VALUE = 16'd1035;
  localparam int          CNT_W       = $clog2(WORD_W);

  typedef enum logic {IDLE, SHIFT} asm_state_t;

endpackage

// File: rtl/serial_word_assembler.sv
// Framed serial bits -> WORD_W-bit words; word visible 1 cycle after its last bit.
// Assembly never stalls: a word completing into a held, unaccepted word is dropped with overrun_o.
module serial_word_assembler
  import decoder_pkg::*;
#(
  parameter int WORD_W    = decoder_pkg::WORD_W,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin_valid,
  input  logic              sin_data,
  input  logic              sin_start,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic              overrun_o,
  output logic              frame_err_o
);

  localparam int             CW   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WORD_W - 1);

  asm_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              vld_q, vld_d;
  logic              ovr_q, ovr_d;
  logic              ferr_q, ferr_d;

  logic              restart, take, complete;
  logic [CW-1:0]     cnt_eff, idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    word_d  = word_q;
    vld_d   = vld_q;
    ovr_d   = 1'b0;
    ferr_d  = 1'b0;

    restart  = sin_valid && sin_start;
    take     = sin_valid && (sin_start || (state_q == SHIFT));
    cnt_eff  = restart ? '0 : cnt_q;
    idx      = LSB_FIRST ? cnt_eff : (LAST - cnt_eff);
    complete = take && (cnt_eff == LAST);

    if (take) begin
      // A start bit always begins a fresh word, whether from IDLE or mid-frame.
      if (restart) sr_d = '0;
      sr_d[idx] = sin_data;
      ferr_d    = restart && (state_q == SHIFT);
      if (complete) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = SHIFT;
        cnt_d   = cnt_eff + 1'b1;
      end
    end

    if (vld_q && word_ready_i) vld_d = 1'b0;

    if (complete) begin
      if (!vld_q || word_ready_i) begin
        word_d = sr_d;
        vld_d  = 1'b1;
      end else begin
        ovr_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      word_q  <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      word_q  <= word_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = vld_q;
  assign overrun_o    = ovr_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: doc/serial_word_assembler.md
Name: serial_word_assembler

Overview:
- Upstream stage of the 1035-pattern decoder; collects a framed serial bit stream into 16-bit parallel words.
- Each completed word is held in an output register with a valid/ready handshake.
- The decoder consumes word_o combinationally while word_valid_o is high.
- Also reports overrun (word lost because the consumer stalled) and aborted frames.

Parameters:
- WORD_W, 16, bits per word; must match the decoder input width.
- LSB_FIRST, 1, 1: first serial bit lands in word bit 0; 0: first bit lands in bit WORD_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- sin_valid  in  1  qualifies sin_data/sin_start this cycle.
- sin_data  in  1  serial data bit.
- sin_start  in  1  marks first bit of a frame; ignored unless sin_valid=1.
- word_o  out  WORD_W  assembled word (output register).
- word_valid_o  out  1  word_o holds an unconsumed word.
- word_ready_i  in  1  consumer accepts word_o when high together with word_valid_o.
- overrun_o  out  1  one-cycle pulse: a completed word was dropped.
- frame_err_o  out  1  one-cycle pulse: a frame was restarted before completion.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - While rst=1 at a rising clk edge: state=IDLE, bit count=0, shift register=0, word_o=0, word_valid_o=0, overrun_o=0, frame_err_o=0.
  - Reset mid-frame discards the partial word and any held word.
- Assembler FSM, states IDLE and SHIFT. Only cycles with sin_valid=1 are considered.
  - IDLE:
    - sin_valid & sin_start: store bit as bit index 0, count=1, go to SHIFT.
    - sin_valid & !sin_start: bit ignored.
  - SHIFT:
    - sin_valid & !sin_start: store bit at index count, count+1.
    - sin_valid & sin_start: abort current frame, pulse frame_err_o next cycle, store bit as index 0, count=1, stay in SHIFT.
    - Bit with count==WORD_W-1: word complete, go to IDLE, count=0.
- Bit placement:
  - LSB_FIRST=1: k-th bit of the frame (k=0..WORD_W-1) goes to word bit k.
  - LSB_FIRST=0: k-th bit goes to word bit WORD_W-1-k.
- Output register (separate from the shift register, so assembly never stalls):
  - The word loads into word_o at the same edge that samples its last bit; word_valid_o=1 in the following cycle.
  - Latency: last bit in → word visible 1 cycle later.
  - Handshake: transfer at an edge where word_valid_o & word_ready_i. Then word_valid_o clears, unless a new word completes at that same edge; in that case the new word loads and valid stays 1, with no overrun.
  - word_o is stable while word_valid_o=1 and word_ready_i=0.
  - Word completes while word_valid_o=1 and word_ready_i=0: new word dropped, held word retained, overrun_o pulses one cycle.
- Pulses:
  - overrun_o and frame_err_o are registered.
  - Each is high exactly one cycle after the causing edge and never sticky.
- Back-to-back frames:
  - sin_start on the cycle immediately after a completing bit is legal and begins a new frame without a bubble.
- sin_valid=0 cycles are gaps: state, count and shift register hold.
- word_ready_i while word_valid_o=0 has no effect.

Decomposition:
- Shared package decoder_pkg:
  - WORD_W=16.
  - MATCH_VALUE=16'd1035 (0x040B), used by the decoder and the bench.
  - asm_state_t enum {IDLE, SHIFT}.
  - Bit-count width localparam $clog2(WORD_W).
- Single module; no sub-module needed. The output holding register is small enough to stay inline.

Test Plan:
- Reset, then feed 1035 LSB-first with no gaps (bits 1,1,0,1,0,0,0,0,0,0,1,0,0,0,0,0; sin_start on the first), word_ready_i=1 → word_o=16'h040B and word_valid_o=1 exactly 1 cycle after the 16th bit, cleared the next cycle.
- Same stream with random sin_valid gaps and LSB_FIRST=0 → word_o=16'hD020; no pulses.
- Hold word_ready_i=0; send frames 0x040B then 0x1234 → word_o stays 0x040B, overrun_o pulses once when 0x1234 completes; raise ready → valid drops, no 0x1234 ever presented.
- word_valid_o=1 with ready asserted on the same edge the next word (0x00FF) completes → word_o=0x00FF, word_valid_o stays 1, overrun_o=0.
- Send 7 bits, then sin_start with a full 16-bit 0x040B frame → frame_err_o pulses once; word_o=0x040B after completion.
- Assert rst after 10 bits of a frame with a held valid word → next cycle word_valid_o=0, word_o=0; a following 16-bit frame assembles correctly from bit 0.
